// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values and the issue-unit state encoding.
// The decode stage's control unit imports the same package.
package cpu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_HALT  = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_CLEAR = 4'd4;
  localparam logic [3:0] OP_SKIP  = 4'd5;
  localparam logic [3:0] OP_JUMP  = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } issue_state_t;

  function automatic logic [3:0] instr_opcode(input logic [15:0] word);
    return word[15:12];
  endfunction

endpackage

// File: rtl/issue_pc_next.sv
// Next-PC selection for the issue unit, applied on the issue handshake.
// All arithmetic wraps modulo 2^ADDR_W.
module issue_pc_next
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] target,
  input  logic              skip_cond,
  output logic [ADDR_W-1:0] next_pc
);

  // Undefined opcodes fall through to the sequential pc+1 default.
  always_comb begin
    next_pc = pc + ADDR_W'(1);
    case (opcode)
      OP_JUMP: next_pc = target;
      OP_SKIP: next_pc = skip_cond ? (pc + ADDR_W'(2)) : (pc + ADDR_W'(1));
      OP_HALT: next_pc = pc;
      default: next_pc = pc + ADDR_W'(1);
    endcase
  end

endmodule

// File: rtl/instr_issue_unit.sv
// Instruction fetch/issue sequencer: fetches one word, presents it to decode,
// then advances the PC on the handshake. Outputs decode only registered state.
module instr_issue_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [3:0]        opcode,
  output logic [15:0]       instr,
  input  logic              skip_cond,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  issue_state_t      state_q;
  issue_state_t      state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next;
  logic [15:0]       instr_q;
  logic              fetch_done;
  logic              issue_fire;

  issue_pc_next #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc        (pc_q),
    .opcode    (instr_opcode(instr_q)),
    .target    (instr_q[ADDR_W-1:0]),
    .skip_cond (skip_cond),
    .next_pc   (pc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // issue_ready only steers next state, never an output, so decode sees no loop.
  always_comb begin
    state_d     = state_q;
    fetch_done  = 1'b0;
    issue_fire  = 1'b0;
    imem_req    = 1'b0;
    issue_valid = 1'b0;
    halted      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          fetch_done = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue_valid = 1'b1;
        if (issue_ready) begin
          issue_fire = 1'b1;
          state_d    = (instr_opcode(instr_q) == OP_HALT) ? ST_HALTED : ST_FETCH;
        end
      end
      ST_HALTED: begin
        halted = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      if (fetch_done) instr_q <= imem_rdata;
      if (issue_fire) pc_q    <= pc_next;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign opcode    = instr_opcode(instr_q);

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench for instr_issue_unit: main instance at RESET_PC=0 plus a
// second instance at RESET_PC=0xFE for the wrap/halt scenario.
module tb_instr_issue_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  opcode;
  logic [15:0] instr;
  logic        skip_cond;
  logic [7:0]  pc;
  logic        halted;

  logic        w_start;
  logic        w_req;
  logic [7:0]  w_addr;
  logic        w_ack;
  logic [15:0] w_rdata;
  logic        w_valid;
  logic        w_ready;
  logic [3:0]  w_opcode;
  logic [15:0] w_instr;
  logic        w_skip;
  logic [7:0]  w_pc;
  logic        w_halted;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int hs_count = 0;
  int overlap = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  logic [15:0] mem [256];

  instr_issue_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .instr(instr), .skip_cond(skip_cond), .pc(pc), .halted(halted)
  );

  instr_issue_unit #(.ADDR_W(8), .RESET_PC(8'hFE)) dut_w (
    .clk(clk), .reset(reset), .start(w_start),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
    .imem_rdata(w_rdata), .issue_valid(w_valid), .issue_ready(w_ready),
    .opcode(w_opcode), .instr(w_instr), .skip_cond(w_skip), .pc(w_pc), .halted(w_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model for the main instance: ack after ack_delay wait cycles, junk data otherwise.
  always @(negedge clk) begin
    if (imem_req && !reset) begin
      if (wait_cnt >= ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
        wait_cnt   = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        wait_cnt   = wait_cnt + 1;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 16'hDEAD;
      wait_cnt   = 0;
    end
  end

  always @(posedge clk) begin
    if (!reset && issue_valid && issue_ready) hs_count = hs_count + 1;
    if (imem_req && issue_valid) overlap = overlap + 1;
    if (w_req && w_valid) overlap = overlap + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cycle = cycle + 1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;   issue_ready = 1'b0; skip_cond = 1'b0;
    w_start = 1'b0; w_ready = 1'b0;     w_skip = 1'b0;
    w_ack = 1'b0;   w_rdata = 16'h0000;
    ack_delay = 0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_handshake(output logic [7:0] hpc, output logic [15:0] hins, output int hcyc);
    bit found = 0;
    hpc = 8'hxx; hins = 16'hxxxx; hcyc = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (issue_valid && issue_ready) begin
        found = 1;
        hpc = pc; hins = instr; hcyc = cycle;
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("[TB] FAIL handshake_timeout: got none within 40 cycles, expected one");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({imem_req, issue_valid, halted, pc, instr} !== {3'b000, 8'h00, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got req=%b valid=%b halted=%b pc=%h instr=%h, expected all zero",
               imem_req, issue_valid, halted, pc, instr);
    end
    checks++;
    if (w_pc !== 8'hFE) begin
      errors++;
      $display("[TB] FAIL reset_pc_fe: got %h expected fe", w_pc);
    end
    do_reset();
    step();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_req: got %b expected 0", imem_req);
    end
  endtask

  task automatic test_straight_line();
    logic [7:0] hpc; logic [15:0] hins; int hcyc; int prev;
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
    issue_ready = 1'b1;
    start_pulse();
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_handshake(hpc, hins, hcyc);
      checks++;
      if (hpc !== 8'(k) || hins !== 16'h0100 + 16'(k)) begin
        errors++;
        $display("[TB] FAIL straight_issue%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                 k, hpc, hins, 8'(k), 16'h0100 + 16'(k));
      end
      if (k > 0) begin
        checks++;
        if (hcyc - prev !== 2) begin
          errors++;
          $display("[TB] FAIL straight_rate%0d: got %0d cycles expected 2", k, hcyc - prev);
        end
      end
      prev = hcyc;
    end
  endtask

  task automatic test_jump();
    logic [7:0] hpc; logic [15:0] hins; int hcyc;
    do_reset();
    mem[0] = 16'h6005; mem[5] = 16'h602A; mem[8'h2A] = 16'h0000;
    issue_ready = 1'b1;
    start_pulse();
    wait_handshake(hpc, hins, hcyc);
    wait_handshake(hpc, hins, hcyc);
    checks++;
    if (hpc !== 8'h05 || opcode !== 4'h6) begin
      errors++;
      $display("[TB] FAIL jump_issue: got pc=%h opcode=%h expected pc=05 opcode=6", hpc, opcode);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h2A) begin
      errors++;
      $display("[TB] FAIL jump_target: got req=%b addr=%h expected req=1 addr=2a", imem_req, imem_addr);
    end
  endtask

  task automatic test_skip(input logic cond, input logic [7:0] exp_addr);
    logic [7:0] hpc; logic [15:0] hins; int hcyc;
    do_reset();
    mem[0] = 16'h600A; mem[10] = 16'h5000; mem[11] = 16'h0000; mem[12] = 16'h0000;
    issue_ready = 1'b1;
    skip_cond = ~cond;
    start_pulse();
    wait_handshake(hpc, hins, hcyc);
    wait_handshake(hpc, hins, hcyc);
    checks++;
    if (hpc !== 8'h0A || hins !== 16'h5000) begin
      errors++;
      $display("[TB] FAIL skip_issue_c%0d: got pc=%h instr=%h expected pc=0a instr=5000", cond, hpc, hins);
    end
    skip_cond = cond;
    step();
    skip_cond = ~cond;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
      errors++;
      $display("[TB] FAIL skip_next_c%0d: got req=%b addr=%h expected req=1 addr=%h",
               cond, imem_req, imem_addr, exp_addr);
    end
  endtask

  task automatic test_backpressure();
    int hs0;
    do_reset();
    mem[0] = 16'h2ABC; mem[1] = 16'h3011;
    issue_ready = 1'b0;
    start_pulse();
    step();
    hs0 = hs_count;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (issue_valid !== 1'b1 || instr !== 16'h2ABC || opcode !== 4'h2 || pc !== 8'h00 || imem_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got valid=%b instr=%h op=%h pc=%h req=%b expected 1 2abc 2 00 0",
                 i, issue_valid, instr, opcode, pc, imem_req);
      end
      step();
    end
    issue_ready = 1'b1;
    ack_delay = 4;
    step();
    issue_ready = 1'b0;
    checks++;
    if (hs_count - hs0 !== 1) begin
      errors++;
      $display("[TB] FAIL stall_one_handshake: got %0d expected 1", hs_count - hs0);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h01 || issue_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wait_req%0d: got req=%b addr=%h valid=%b expected 1 01 0",
                 i, imem_req, imem_addr, issue_valid);
      end
      step();
    end
    checks++;
    if (issue_valid !== 1'b1 || instr !== 16'h3011) begin
      errors++;
      $display("[TB] FAIL wait_latch: got valid=%b instr=%h expected 1 3011", issue_valid, instr);
    end
    ack_delay = 0;
  endtask

  task automatic test_wrap_halt();
    logic [7:0] seen [3];
    int n = 0;
    bit done = 0;
    do_reset();
    w_ready = 1'b1;
    w_ack   = 1'b1;
    w_start = 1'b1;
    step();
    w_start = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      w_rdata = (w_addr == 8'hFE || w_addr == 8'hFF) ? 16'h0042 : 16'h1000;
      if (w_valid && w_ready) begin
        if (n < 3) seen[n] = w_pc;
        n++;
      end
      step();
      if (w_halted) done = 1;
    end
    checks++;
    if (n !== 3 || seen[0] !== 8'hFE || seen[1] !== 8'hFF || seen[2] !== 8'h00) begin
      errors++;
      $display("[TB] FAIL wrap_sequence: got n=%0d pcs=%h %h %h expected 3 fe ff 00", n, seen[0], seen[1], seen[2]);
    end
    checks++;
    if (w_halted !== 1'b1 || w_pc !== 8'h00 || w_req !== 1'b0 || w_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_state: got halted=%b pc=%h req=%b valid=%b expected 1 00 0 0",
               w_halted, w_pc, w_req, w_valid);
    end
    for (int i = 0; i < 3; i++) begin
      w_start = 1'b1;
      step();
      checks++;
      if (w_req !== 1'b0 || w_halted !== 1'b1) begin
        errors++;
        $display("[TB] FAIL halt_start%0d: got req=%b halted=%b expected 0 1", i, w_req, w_halted);
      end
    end
    w_start = 1'b0;
    w_ack = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [7:0] hpc; logic [15:0] hins; int hcyc; int hs0;
    do_reset();
    mem[0] = 16'h6033; mem[8'h33] = 16'h0000;
    issue_ready = 1'b1;
    hs0 = hs_count;
    start_pulse();
    wait_handshake(hpc, hins, hcyc);
    ack_delay = 10;
    step();
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h33 || instr !== 16'h6033) begin
      errors++;
      $display("[TB] FAIL midop_pending: got req=%b addr=%h instr=%h expected 1 33 6033", imem_req, imem_addr, instr);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({imem_req, issue_valid, halted, pc, instr} !== {3'b000, 8'h00, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL midop_async: got req=%b valid=%b halted=%b pc=%h instr=%h expected all zero",
               imem_req, issue_valid, halted, pc, instr);
    end
    step();
    reset = 1'b0;
    ack_delay = 0;
    step();
    step();
    checks++;
    if (imem_req !== 1'b0 || issue_valid !== 1'b0 || hs_count - hs0 !== 1) begin
      errors++;
      $display("[TB] FAIL midop_no_issue: got req=%b valid=%b handshakes=%0d expected 0 0 1",
               imem_req, issue_valid, hs_count - hs0);
    end
  endtask

  task automatic test_no_overlap();
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("[TB] FAIL req_valid_overlap: got %0d cycles expected 0", overlap);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; issue_ready = 1'b0; skip_cond = 1'b0;
    w_start = 1'b0; w_ready = 1'b0; w_skip = 1'b0; w_ack = 1'b0; w_rdata = 16'h0000;
    imem_ack = 1'b0; imem_rdata = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_straight_line();
    test_jump();
    test_skip(1'b1, 8'h0C);
    test_skip(1'b0, 8'h0B);
    test_backpressure();
    test_wrap_halt();
    test_reset_midop();
    test_no_overlap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
